// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: panel-side and pixel-source signals of the LCD timing generator
interface lcd_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic [15:0]      lcd_id;
  logic [23:0]      pixel_data;
  logic             data_req;
  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
  logic [CNT_W-1:0] h_disp;
  logic [CNT_W-1:0] v_disp;
  logic             lcd_de;
  logic             lcd_hs;
  logic             lcd_vs;
  logic [23:0]      lcd_rgb;
  logic             lcd_rst;
  logic             lcd_bl;
  modport master (
    input  lcd_id, pixel_data,
    output data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
    output lcd_de, lcd_hs, lcd_vs, lcd_rgb, lcd_rst, lcd_bl
  );
  modport slave (
    output lcd_id, pixel_data,
    input  data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
    input  lcd_de, lcd_hs, lcd_vs, lcd_rgb, lcd_rst, lcd_bl
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: panel-ID driven RGB LCD timing generator with a one-clock-early pixel request
module lcd_timing_gen #(
  parameter int CNT_W      = 11,
  parameter int SETTLE_CYC = 16
) (
  input logic              clk,
  input logic              rst_n,
  lcd_timing_gen_if.master bus
);
  typedef enum logic [1:0] {WAIT_ID, SETTLE, RUN} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    cnt_t hs, hb, hd, hf, ht, vs, vb, vd, vf, vt;
  } timing_t;
  localparam cnt_t       ONE         = cnt_t'(1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  function automatic timing_t mk(input int hs, hb, hd, hf, ht, vs, vb, vd, vf, vt);
    return '{cnt_t'(hs), cnt_t'(hb), cnt_t'(hd), cnt_t'(hf), cnt_t'(ht),
             cnt_t'(vs), cnt_t'(vb), cnt_t'(vd), cnt_t'(vf), cnt_t'(vt)};
  endfunction
  state_t     state_q, state_d;
  timing_t    tm_q, tm_d, tbl;
  cnt_t       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
  logic [7:0] settle_q, settle_d;
  logic       rst_q, rst_d, bl_q, bl_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d, req_q, req_d;
  logic       hit, h_wrap, v_wrap, h_act, h_pre, v_act, unused_porch;
  cnt_t       ha, va;
  always_comb begin
    hit = 1'b1;
    case (bus.lcd_id)
      16'h4342: tbl = mk(41, 2, 480, 2, 525, 10, 2, 272, 2, 286);
      16'h7084: tbl = mk(128, 88, 800, 40, 1056, 2, 33, 480, 10, 525);
      16'h7016: tbl = mk(20, 140, 1024, 160, 1344, 3, 20, 600, 12, 635);
      16'h4384: tbl = mk(128, 88, 800, 40, 1056, 2, 33, 480, 10, 525);
      16'h1018: tbl = mk(10, 80, 1280, 70, 1440, 3, 10, 800, 10, 823);
      default: begin
        tbl = '0;
        hit = 1'b0;
      end
    endcase
  end
  // front porches are implied by the totals; kept in the latched set only
  assign unused_porch = ^{tm_q.hf, tm_q.vf};
  assign ha     = tm_q.hs + tm_q.hb;
  assign va     = tm_q.vs + tm_q.vb;
  assign h_wrap = h_cnt_q == tm_q.ht - ONE;
  assign v_wrap = v_cnt_q == tm_q.vt - ONE;
  assign h_act  = h_cnt_q >= ha && h_cnt_q < ha + tm_q.hd;
  assign h_pre  = h_cnt_q >= ha - ONE && h_cnt_q < ha + tm_q.hd - ONE;
  assign v_act  = v_cnt_q >= va && v_cnt_q < va + tm_q.vd;
  always_comb begin
    state_d  = state_q;
    tm_d     = tm_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    settle_d = settle_q;
    rst_d    = rst_q;
    bl_d     = bl_q;
    de_d     = 1'b0;
    req_d    = 1'b0;
    hs_d     = 1'b1;
    vs_d     = 1'b1;
    x_d      = '0;
    y_d      = '0;
    case (state_q)
      WAIT_ID: if (hit) begin
        state_d  = SETTLE;
        tm_d     = tbl;
        settle_d = '0;
      end
      SETTLE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
          rst_d   = 1'b1;
          bl_d    = 1'b1;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      RUN: begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + ONE;
        v_cnt_d = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + ONE;
        hs_d    = h_cnt_q >= tm_q.hs;
        vs_d    = v_cnt_q >= tm_q.vs;
        de_d    = h_act && v_act;
        // request runs one column ahead so returned data lands with DE
        req_d   = h_pre && v_act;
        x_d     = req_d ? h_cnt_q - (ha - ONE) : '0;
        y_d     = req_d ? v_cnt_q - va : '0;
      end
      default: state_d = WAIT_ID;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WAIT_ID;
      tm_q     <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      settle_q <= '0;
      rst_q    <= 1'b0;
      bl_q     <= 1'b0;
      de_q     <= 1'b0;
      req_q    <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      tm_q     <= tm_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      settle_q <= settle_d;
      rst_q    <= rst_d;
      bl_q     <= bl_d;
      de_q     <= de_d;
      req_q    <= req_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end
  assign bus.data_req   = req_q;
  assign bus.pixel_xpos = x_q;
  assign bus.pixel_ypos = y_q;
  assign bus.h_disp     = tm_q.hd;
  assign bus.v_disp     = tm_q.vd;
  assign bus.lcd_de     = de_q;
  assign bus.lcd_hs     = hs_q;
  assign bus.lcd_vs     = vs_q;
  assign bus.lcd_rst    = rst_q;
  assign bus.lcd_bl     = bl_q;
  assign bus.lcd_rgb    = de_q ? bus.pixel_data : '0;
endmodule
